// File: rtl/ddr3_test_pkg.sv
// Shared constants and PRBS helpers for the DDR3 traffic generator/checker.
package ddr3_test_pkg;

  localparam int unsigned LaneW    = 32;
  localparam int unsigned MaxLanes = 8;

  // Feedback taps of x^32 + x^22 + x^2 + x + 1 (Fibonacci form, shift towards MSB).
  localparam int unsigned TapA = 31;
  localparam int unsigned TapB = 21;
  localparam int unsigned TapC = 1;
  localparam int unsigned TapD = 0;

  // Per-lane salts decorrelate the lanes when they all start from the same seed.
  localparam logic [31:0] LANE_SALT [0:MaxLanes-1] = '{
    32'h00000000, 32'h9E3779B9, 32'h3C6EF372, 32'hDAA66D2B,
    32'h78DDE6E4, 32'h1715609D, 32'hB54CDA56, 32'h5384540F
  };

  // Generator / checker FSM encodings.
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[TapA] ^ s[TapB] ^ s[TapC] ^ s[TapD]};
  endfunction

  // An all-zero LFSR state would lock up, so it is replaced by 1.
  function automatic logic [31:0] lane_seed(input logic [31:0] seed, input int unsigned idx);
    logic [31:0] s;
    s = seed ^ LANE_SALT[idx[2:0]];
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/prbs_word.sv
// Bank of 32-bit LFSR lanes forming one wide PRBS word; load has priority over step.
module prbs_word
  import ddr3_test_pkg::*;
#(
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [31:0]       seed,
  input  logic              step,
  output logic [DATA_W-1:0] word
);

  localparam int unsigned Lanes = DATA_W / LaneW;

  logic [DATA_W-1:0] word_d, word_q;

  // Next lane states: reseed on load, advance every lane on step.
  always_comb begin
    word_d = word_q;
    for (int unsigned i = 0; i < Lanes; i++) begin
      if (load) begin
        word_d[i*LaneW +: LaneW] = lane_seed(seed, i);
      end else if (step) begin
        word_d[i*LaneW +: LaneW] = lfsr_next(word_q[i*LaneW +: LaneW]);
      end
    end
  end

  // Lane registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/ddr3_prbs_gen_chk.sv
// PRBS traffic source (into the DDR3 write FIFO) and sink/checker (from the read FIFO).
module ddr3_prbs_gen_chk
  import ddr3_test_pkg::*;
#(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned CNT_W  = 28,
  parameter int unsigned ERR_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              gen_start,
  input  logic              chk_start,
  input  logic [31:0]       seed,
  input  logic [CNT_W-1:0]  word_count,
  output logic              gen_wr_en,
  output logic [DATA_W-1:0] gen_data,
  input  logic              gen_full,
  output logic              chk_rd_en,
  input  logic [DATA_W-1:0] chk_data,
  input  logic              chk_valid,
  input  logic              chk_empty,
  output logic              gen_busy,
  output logic              chk_busy,
  output logic              gen_done,
  output logic              chk_done,
  output logic [ERR_W-1:0]  err_count,
  output logic [CNT_W-1:0]  first_err
);

  logic [0:0]        gen_state_d, gen_state_q;
  logic [CNT_W-1:0]  gen_rem_d, gen_rem_q;
  logic              gen_done_d, gen_done_q;
  logic              gen_load;

  logic [0:0]        chk_state_d, chk_state_q;
  logic [CNT_W-1:0]  chk_rem_d, chk_rem_q;
  logic [CNT_W-1:0]  chk_issued_d, chk_issued_q;
  logic [CNT_W-1:0]  chk_idx_d, chk_idx_q;
  logic [ERR_W-1:0]  chk_err_d, chk_err_q;
  logic [CNT_W-1:0]  chk_first_d, chk_first_q;
  logic              chk_done_d, chk_done_q;
  logic              chk_rd_en_d, chk_rd_en_q;
  logic              chk_load, chk_step;
  logic [DATA_W-1:0] chk_exp;

  prbs_word #(
    .DATA_W (DATA_W)
  ) u_gen_prbs (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (gen_load),
    .seed    (seed),
    .step    (gen_wr_en),
    .word    (gen_data)
  );

  prbs_word #(
    .DATA_W (DATA_W)
  ) u_chk_prbs (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (chk_load),
    .seed    (seed),
    .step    (chk_step),
    .word    (chk_exp)
  );

  // Generator: one write per cycle whenever the input FIFO has room.
  always_comb begin
    gen_state_d = gen_state_q;
    gen_rem_d   = gen_rem_q;
    gen_done_d  = gen_done_q;
    gen_load    = 1'b0;
    gen_wr_en   = (gen_state_q == StRun) && !gen_full && (gen_rem_q != '0);
    unique case (gen_state_q)
      StIdle: begin
        if (gen_start) begin
          gen_load   = 1'b1;
          gen_rem_d  = word_count;
          gen_done_d = (word_count == '0);
          if (word_count != '0) gen_state_d = StRun;
        end
      end
      StRun: begin
        if (gen_wr_en) begin
          gen_rem_d = gen_rem_q - CNT_W'(1);
          if (gen_rem_q == CNT_W'(1)) begin
            gen_done_d  = 1'b1;
            gen_state_d = StIdle;
          end
        end
      end
      default: gen_state_d = StIdle;
    endcase
  end

  // Checker: at most one read in flight, compare each returned word against the local PRBS.
  always_comb begin
    chk_state_d  = chk_state_q;
    chk_rem_d    = chk_rem_q;
    chk_issued_d = chk_issued_q;
    chk_idx_d    = chk_idx_q;
    chk_err_d    = chk_err_q;
    chk_first_d  = chk_first_q;
    chk_done_d   = chk_done_q;
    chk_rd_en_d  = 1'b0;
    chk_load     = 1'b0;
    chk_step     = 1'b0;
    unique case (chk_state_q)
      StIdle: begin
        if (chk_start) begin
          chk_load     = 1'b1;
          chk_rem_d    = word_count;
          chk_issued_d = '0;
          chk_idx_d    = '0;
          chk_err_d    = '0;
          chk_first_d  = '1;
          chk_done_d   = (word_count == '0);
          if (word_count != '0) chk_state_d = StRun;
        end
      end
      StRun: begin
        // issued tracks reads sent to the FIFO whose data has not yet been compared.
        if (chk_rd_en_q) chk_issued_d = chk_issued_q + CNT_W'(1);
        if (chk_valid && (chk_rem_q != '0)) begin
          chk_step = 1'b1;
          if (chk_issued_d != '0) chk_issued_d = chk_issued_d - CNT_W'(1);
          if (chk_data != chk_exp) begin
            if (chk_err_q != '1) chk_err_d = chk_err_q + ERR_W'(1);
            if (chk_first_q == '1) chk_first_d = chk_idx_q;
          end
          chk_idx_d = chk_idx_q + CNT_W'(1);
          chk_rem_d = chk_rem_q - CNT_W'(1);
          if (chk_rem_q == CNT_W'(1)) begin
            chk_done_d  = 1'b1;
            chk_state_d = StIdle;
          end
        end
        chk_rd_en_d = (chk_state_d == StRun) && !chk_empty && !chk_rd_en_q &&
                      (chk_issued_d < chk_rem_d);
      end
      default: chk_state_d = StIdle;
    endcase
  end

  // State registers for both engines; reset aborts any run and drops the read strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gen_state_q  <= StIdle;
      gen_rem_q    <= '0;
      gen_done_q   <= 1'b0;
      chk_state_q  <= StIdle;
      chk_rem_q    <= '0;
      chk_issued_q <= '0;
      chk_idx_q    <= '0;
      chk_err_q    <= '0;
      chk_first_q  <= '1;
      chk_done_q   <= 1'b0;
      chk_rd_en_q  <= 1'b0;
    end else begin
      gen_state_q  <= gen_state_d;
      gen_rem_q    <= gen_rem_d;
      gen_done_q   <= gen_done_d;
      chk_state_q  <= chk_state_d;
      chk_rem_q    <= chk_rem_d;
      chk_issued_q <= chk_issued_d;
      chk_idx_q    <= chk_idx_d;
      chk_err_q    <= chk_err_d;
      chk_first_q  <= chk_first_d;
      chk_done_q   <= chk_done_d;
      chk_rd_en_q  <= chk_rd_en_d;
    end
  end

  assign gen_busy  = (gen_state_q == StRun);
  assign chk_busy  = (chk_state_q == StRun);
  assign gen_done  = gen_done_q;
  assign chk_done  = chk_done_q;
  assign chk_rd_en = chk_rd_en_q;
  assign err_count = chk_err_q;
  assign first_err = chk_first_q;

endmodule

// File: tb/tb_ddr3_prbs_gen_chk.sv
// Directed bench: PRBS vector table, stall/loopback/error/reset sequences around a model FIFO.
module tb_ddr3_prbs_gen_chk;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned CNT_W  = 28;
  localparam int unsigned ERR_W  = 32;

  logic              clk;
  logic              reset_n;
  logic              gen_start, chk_start;
  logic [31:0]       seed;
  logic [CNT_W-1:0]  word_count;
  logic              gen_wr_en;
  logic [DATA_W-1:0] gen_data;
  logic              gen_full;
  logic              chk_rd_en;
  logic [DATA_W-1:0] chk_data;
  logic              chk_valid;
  logic              chk_empty;
  logic              gen_busy, chk_busy, gen_done, chk_done;
  logic [ERR_W-1:0]  err_count;
  logic [CNT_W-1:0]  first_err;

  ddr3_prbs_gen_chk #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .ERR_W  (ERR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .gen_start  (gen_start),
    .chk_start  (chk_start),
    .seed       (seed),
    .word_count (word_count),
    .gen_wr_en  (gen_wr_en),
    .gen_data   (gen_data),
    .gen_full   (gen_full),
    .chk_rd_en  (chk_rd_en),
    .chk_data   (chk_data),
    .chk_valid  (chk_valid),
    .chk_empty  (chk_empty),
    .gen_busy   (gen_busy),
    .chk_busy   (chk_busy),
    .gen_done   (gen_done),
    .chk_done   (chk_done),
    .err_count  (err_count),
    .first_err  (first_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] seed;
    int          idx;
    int          lane;
    logic [31:0] exp;
  } vec_t;

  logic [31:0] tb_salt [8] = '{32'h00000000, 32'h9E3779B9, 32'h3C6EF372, 32'hDAA66D2B,
                               32'h78DDE6E4, 32'h1715609D, 32'hB54CDA56, 32'h5384540F};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [DATA_W-1:0] fifo[$];
  logic [DATA_W-1:0] wr_log[$];
  logic [DATA_W-1:0] ref_log[$];
  logic              pend_v;
  logic [DATA_W-1:0] pend_d;
  bit                rand_en = 1'b0;
  int                full_lo = -1, full_hi = -1, corrupt_idx = -1;
  int                rd_strobes, rd_b2b, stall_bad;
  logic              prev_stall, prev_rd;
  logic [DATA_W-1:0] prev_data;
  vec_t              vecs [13];

  function automatic logic [DATA_W-1:0] model_word(input logic [31:0] s, input int idx);
    logic [DATA_W-1:0] w;
    logic [31:0] l;
    w = '0;
    for (int ln = 0; ln < DATA_W / 32; ln++) begin
      l = s ^ tb_salt[ln];
      if (l == 32'h0) l = 32'h1;
      for (int k = 0; k < idx; k++) l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
      w[ln*32 +: 32] = l;
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive this cycle's inputs at negedge, then model FIFO push/pop for the posedge.
  task automatic tick();
    logic [DATA_W-1:0] w;
    @(negedge clk);
    cyc++;
    gen_start = 1'b0;
    chk_start = 1'b0;
    gen_full  = (rand_en && $urandom_range(0, 3) == 0) || (cyc >= full_lo && cyc <= full_hi);
    chk_valid = pend_v;
    chk_data  = pend_d;
    pend_v    = 1'b0;
    chk_empty = (fifo.size() == 0) || (rand_en && !chk_rd_en && $urandom_range(0, 2) == 0);
    #1;
    if (gen_full && gen_busy) begin
      if (prev_stall && gen_data !== prev_data) stall_bad++;
      if (gen_wr_en) stall_bad++;
    end
    prev_stall = gen_full && gen_busy;
    prev_data  = gen_data;
    if (gen_wr_en) begin
      w = gen_data;
      if (wr_log.size() == corrupt_idx) w[200] = ~w[200];
      wr_log.push_back(gen_data);
      fifo.push_back(w);
    end
    if (chk_rd_en) begin
      rd_strobes++;
      if (prev_rd) rd_b2b++;
      if (fifo.size() > 0) begin
        pend_d = fifo.pop_front();
        pend_v = 1'b1;
      end
    end
    prev_rd = chk_rd_en;
  endtask

  task automatic clear_logs();
    fifo.delete();
    wr_log.delete();
    pend_v     = 1'b0;
    rd_strobes = 0;
    rd_b2b     = 0;
    stall_bad  = 0;
    prev_stall = 1'b0;
    prev_rd    = 1'b0;
  endtask

  task automatic start(input logic [31:0] s, input int n, input bit g, input bit c);
    seed       = s;
    word_count = CNT_W'(n);
    gen_start  = g;
    chk_start  = c;
  endtask

  task automatic run_gen(input int bound);
    tick();
    for (int i = 0; i < bound && !gen_done; i++) tick();
  endtask

  task automatic run_chk(input int bound);
    tick();
    for (int i = 0; i < bound && !chk_done; i++) tick();
  endtask

  initial begin
    logic [31:0] cur_seed;
    bit          have_run;
    logic [31:0] act;

    vecs[0]  = '{32'h00000001, 0, 0, 32'h00000001};
    vecs[1]  = '{32'h00000001, 0, 1, 32'h9E3779B8};
    vecs[2]  = '{32'h00000001, 1, 0, 32'h00000003};
    vecs[3]  = '{32'h00000001, 2, 0, 32'h00000006};
    vecs[4]  = '{32'h00000001, 3, 0, 32'h0000000D};
    vecs[5]  = '{32'h00000001, 1, 1, 32'h3C6EF370};
    vecs[6]  = '{32'h00000000, 0, 0, 32'h00000001};
    vecs[7]  = '{32'h00000000, 0, 1, 32'h9E3779B9};
    vecs[8]  = '{32'h00000000, 0, 2, 32'h3C6EF372};
    vecs[9]  = '{32'h00000000, 0, 7, 32'h5384540F};
    vecs[10] = '{32'h00000000, 1, 0, 32'h00000003};
    vecs[11] = '{32'h3C6EF372, 0, 2, 32'h00000001};
    vecs[12] = '{32'h3C6EF372, 0, 0, 32'h3C6EF372};

    reset_n = 1'b0; gen_start = 1'b0; chk_start = 1'b0; seed = '0; word_count = '0;
    gen_full = 1'b0; chk_data = '0; chk_valid = 1'b0; chk_empty = 1'b1;
    clear_logs();
    tick();
    // Start pulses coincident with reset must be ignored.
    start(32'h1, 4, 1'b1, 1'b1);
    tick();
    check("rst_gen_busy", gen_busy, 0);
    check("rst_chk_busy", chk_busy, 0);
    check("rst_strobes", {gen_wr_en, chk_rd_en}, 0);
    check("rst_done", {gen_done, chk_done}, 0);
    check("rst_err_count", err_count, 0);
    check("rst_first_err", first_err, {CNT_W{1'b1}});
    check("rst_gen_data", gen_data, 0);
    reset_n = 1'b1;
    tick();

    // Basic run: four back-to-back writes, done the cycle after the last one.
    clear_logs();
    start(32'h1, 4, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t1_wr_en_%0d", k), gen_wr_en, 1);
    end
    tick();
    check("t1_wr_en_after", gen_wr_en, 0);
    check("t1_gen_done", gen_done, 1);
    check("t1_gen_busy", gen_busy, 0);
    check("t1_writes", wr_log.size(), 4);

    // Hand-computed lane values per seed.
    have_run = 1'b0;
    cur_seed = '0;
    for (int v = 0; v < 13; v++) begin
      if (!have_run || vecs[v].seed != cur_seed) begin
        clear_logs();
        tick();
        start(vecs[v].seed, 4, 1'b1, 1'b0);
        run_gen(50);
        cur_seed = vecs[v].seed;
        have_run = 1'b1;
      end
      act = (vecs[v].idx < wr_log.size()) ? wr_log[vecs[v].idx][vecs[v].lane*32 +: 32] : 'x;
      check($sformatf("vec%0d", v), act, vecs[v].exp);
    end

    // Unstalled reference run, then the same run stalled by gen_full.
    clear_logs();
    start(32'h12345678, 8, 1'b1, 1'b0);
    run_gen(100);
    ref_log = wr_log;
    check("t2_ref_writes", ref_log.size(), 8);
    for (int i = 0; i < 8 && i < ref_log.size(); i++)
      check($sformatf("t2_model_%0d", i), ref_log[i], model_word(32'h12345678, i));
    clear_logs();
    start(32'h12345678, 8, 1'b1, 1'b0);
    full_lo = cyc + 2;
    full_hi = cyc + 5;
    run_gen(100);
    full_lo = -1;
    full_hi = -1;
    check("t2_stall_writes", wr_log.size(), 8);
    check("t2_stall_hold", stall_bad, 0);
    for (int i = 0; i < 8 && i < wr_log.size() && i < ref_log.size(); i++)
      check($sformatf("t2_stall_word_%0d", i), wr_log[i], ref_log[i]);

    // Loopback through the model FIFO with random full/empty.
    clear_logs();
    rand_en = 1'b1;
    start(32'hDEADBEEF, 1000, 1'b1, 1'b1);
    run_chk(20000);
    rand_en = 1'b0;
    check("t3_chk_done", chk_done, 1);
    check("t3_gen_done", gen_done, 1);
    check("t3_err_count", err_count, 0);
    check("t3_first_err", first_err, {CNT_W{1'b1}});
    check("t3_writes", wr_log.size(), 1000);
    check("t3_reads", rd_strobes, 1000);
    check("t3_read_spacing", rd_b2b, 0);

    // Single corrupted word in the FIFO.
    clear_logs();
    corrupt_idx = 17;
    rand_en = 1'b1;
    start(32'hDEADBEEF, 40, 1'b1, 1'b1);
    run_chk(3000);
    rand_en = 1'b0;
    corrupt_idx = -1;
    check("t4_chk_done", chk_done, 1);
    check("t4_err_count", err_count, 1);
    check("t4_first_err", first_err, 17);

    // Reset in the middle of a 10-word run.
    clear_logs();
    tick();
    start(32'hCAFEF00D, 10, 1'b1, 1'b0);
    for (int i = 0; i < 100 && wr_log.size() < 5; i++) tick();
    check("t6_reached_word5", wr_log.size(), 5);
    reset_n = 1'b0;
    tick();
    check("t6_rst_wr_en", gen_wr_en, 0);
    check("t6_rst_busy", gen_busy, 0);
    check("t6_rst_flags", {gen_done, chk_done}, 0);
    check("t6_rst_err", err_count, 0);
    check("t6_rst_first", first_err, {CNT_W{1'b1}});
    check("t6_rst_data", gen_data, 0);
    reset_n = 1'b1;
    tick();

    // Zero word count: done on the next cycle with no strobes.
    clear_logs();
    start(32'h5, 0, 1'b1, 1'b1);
    tick();
    check("t5_zero_done", {gen_done, chk_done}, 2'b11);
    check("t5_zero_busy", {gen_busy, chk_busy}, 0);
    for (int i = 0; i < 3; i++) tick();
    check("t5_zero_strobes", wr_log.size() + rd_strobes, 0);

    // Restart after reset reproduces the sequence from word 0.
    clear_logs();
    start(32'hCAFEF00D, 10, 1'b1, 1'b0);
    run_gen(100);
    check("t6_restart_writes", wr_log.size(), 10);
    check("t6_restart_word0", (wr_log.size() > 0) ? wr_log[0] : 'x, model_word(32'hCAFEF00D, 0));

    // gen_start during RUN is ignored.
    clear_logs();
    start(32'hA5A5A5A5, 6, 1'b1, 1'b0);
    tick();
    tick();
    start(32'h0BADF00D, 2, 1'b1, 1'b0);
    run_gen(100);
    check("t5_ignore_writes", wr_log.size(), 6);
    check("t5_ignore_word5", (wr_log.size() > 5) ? wr_log[5] : 'x, model_word(32'hA5A5A5A5, 5));

    // chk_start during RUN is ignored; nothing to read keeps the checker waiting.
    clear_logs();
    start(32'h1, 3, 1'b0, 1'b1);
    tick();
    start(32'h1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("t5_chk_still_busy", chk_busy, 1);
    check("t5_chk_not_done", chk_done, 0);
    check("t5_chk_no_read", rd_strobes, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
